// File: rtl/sync_filter.sv
// Multi-channel asynchronous input synchronizer with per-channel glitch filter
// and registered single-cycle rise/fall pulses.
`timescale 1ns/1ps

module sync_filter #(
  parameter int unsigned       WIDTH      = 2,
  parameter int unsigned       STAGES     = 2,
  parameter int unsigned       FILTER_LEN = 3,
  parameter logic [WIDTH-1:0]  RST_VAL    = '0
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  // Counter only needs to reach FILTER_LEN-1; keep at least one bit.
  localparam int unsigned CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  if (STAGES < 2) begin : g_bad_stages
    $fatal(1, "sync_filter: STAGES must be at least 2");
  end

  if (FILTER_LEN < 1) begin : g_bad_filter
    $fatal(1, "sync_filter: FILTER_LEN must be at least 1");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic [STAGES-1:0] stage;
    logic              s;
    logic              f;
    logic              f_next;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_next;
    logic              rise_r;
    logic              fall_r;

    // Plain flop chain: nothing may sit between these registers.
    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
        stage <= {STAGES{RST_VAL[i]}};
      end else begin
        stage <= {stage[STAGES-2:0], async_in[i]};
      end
    end

    assign s = stage[STAGES-1];

    always_comb begin
      f_next   = f;
      cnt_next = '0;
      if (s != f) begin
        if (cnt == CNT_LAST) begin
          f_next = s;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
        f      <= RST_VAL[i];
        cnt    <= '0;
        rise_r <= 1'b0;
        fall_r <= 1'b0;
      end else begin
        f      <= f_next;
        cnt    <= cnt_next;
        rise_r <= f_next & ~f;
        fall_r <= ~f_next & f;
      end
    end

    assign sync_out[i] = f;
    assign rise[i]     = rise_r;
    assign fall[i]     = fall_r;
  end

endmodule

// File: tb/tb_sync_filter.sv
// Self-checking bench for sync_filter: directed vector table, reset corner
// cases, and randomized traffic against a sample-window reference model.
`timescale 1ns/1ps

module tb_sync_filter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Default configuration instance
  logic       nr_d;
  logic [1:0] in_d, so_d, ri_d, fa_d;
  sync_filter u_def (
    .clk(clk), .n_rst(nr_d), .async_in(in_d),
    .sync_out(so_d), .rise(ri_d), .fall(fa_d)
  );

  // I2C-style instance, lines idle high
  logic       nr_i;
  logic [1:0] in_i, so_i, ri_i, fa_i;
  sync_filter #(.RST_VAL(2'b11)) u_i2c (
    .clk(clk), .n_rst(nr_i), .async_in(in_i),
    .sync_out(so_i), .rise(ri_i), .fall(fa_i)
  );

  // Wide instance, deeper chain, no filtering
  logic       nr_w;
  logic [7:0] in_w, so_w, ri_w, fa_w;
  sync_filter #(.WIDTH(8), .STAGES(3), .FILTER_LEN(1)) u_wide (
    .clk(clk), .n_rst(nr_w), .async_in(in_w),
    .sync_out(so_w), .rise(ri_w), .fall(fa_w)
  );

  // Reference model: h holds raw input samples, bit k = sample taken k edges
  // ago. The accepted level flips once the last FILTER_LEN synchronized samples
  // (those STAGES..STAGES+FILTER_LEN-1 edges old) all disagree with it.
  function automatic logic flips(input logic [15:0] h, input logic f,
                                 input int st, input int fl);
    for (int k = st; k < st + fl; k++) begin
      if (h[k] == f) return 1'b0;
    end
    return 1'b1;
  endfunction

  logic [15:0] hd [2];
  logic [1:0]  mf_d, mr_d, mfl_d;
  logic [15:0] hw [8];
  logic [7:0]  mf_w, mr_w, mfl_w;
  logic [7:0]  wq[$];

  always @(posedge clk) begin
    for (int ch = 0; ch < 2; ch++) begin
      logic [15:0] h;
      logic        nf;
      if (!nr_d) begin
        hd[ch] <= '0; mf_d[ch] <= 1'b0; mr_d[ch] <= 1'b0; mfl_d[ch] <= 1'b0;
      end else begin
        h  = {hd[ch][14:0], in_d[ch]};
        nf = mf_d[ch] ^ flips(h, mf_d[ch], 2, 3);
        hd[ch]    <= h;
        mf_d[ch]  <= nf;
        mr_d[ch]  <= nf & ~mf_d[ch];
        mfl_d[ch] <= ~nf & mf_d[ch];
      end
    end
  end

  always @(posedge clk) begin
    for (int ch = 0; ch < 8; ch++) begin
      logic [15:0] h;
      logic        nf;
      if (!nr_w) begin
        hw[ch] <= '0; mf_w[ch] <= 1'b0; mr_w[ch] <= 1'b0; mfl_w[ch] <= 1'b0;
      end else begin
        h  = {hw[ch][14:0], in_w[ch]};
        nf = mf_w[ch] ^ flips(h, mf_w[ch], 3, 1);
        hw[ch]    <= h;
        mf_w[ch]  <= nf;
        mr_w[ch]  <= nf & ~mf_w[ch];
        mfl_w[ch] <= ~nf & mf_w[ch];
      end
    end
    wq.push_back(nr_w ? in_w : 8'h00);
    if (wq.size() > 8) void'(wq.pop_front());
  end

  task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step_d(input logic [1:0] v, input logic [1:0] so, input logic [1:0] ri,
                        input logic [1:0] fa, input string nm);
    in_d = v;
    @(negedge clk);
    chk(nm, 24'({so_d, ri_d, fa_d}), 24'({so, ri, fa}));
  endtask

  task automatic step_i(input logic [1:0] v, input logic [1:0] so, input logic [1:0] ri,
                        input logic [1:0] fa, input string nm);
    in_i = v;
    @(negedge clk);
    chk(nm, 24'({so_i, ri_i, fa_i}), 24'({so, ri, fa}));
  endtask

  typedef struct {
    logic [1:0] v;
    logic [1:0] so;
    logic [1:0] ri;
    logic [1:0] fa;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [1:0] v, input logic [1:0] so,
                     input logic [1:0] ri, input logic [1:0] fa);
    vec_t r;
    r.v = v; r.so = so; r.ri = ri; r.fa = fa;
    tbl.push_back(r);
  endtask

  initial begin
    nr_d = 1'b0; nr_i = 1'b0; nr_w = 1'b0;
    in_d = 2'b00; in_i = 2'b11; in_w = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_def",  24'({so_d, ri_d, fa_d}), 24'h0);
    chk("rst_i2c",  24'({so_i, ri_i, fa_i}), 24'({2'b11, 4'b0000}));
    chk("rst_wide", 24'({so_w, ri_w, fa_w}), 24'h0);
    nr_d = 1'b1; nr_i = 1'b1; nr_w = 1'b1;

    // I2C: idle release, SDA low, then release with inputs away from idle
    for (int k = 0; k < 3; k++) step_i(2'b11, 2'b11, 2'b00, 2'b00, "i2c_idle");
    for (int k = 0; k < 4; k++) step_i(2'b01, 2'b11, 2'b00, 2'b00, "i2c_sda_wait");
    step_i(2'b01, 2'b01, 2'b00, 2'b10, "i2c_sda_fall");
    for (int k = 0; k < 2; k++) step_i(2'b01, 2'b01, 2'b00, 2'b00, "i2c_sda_hold");
    nr_i = 1'b0;
    in_i = 2'b00;
    @(negedge clk);
    chk("i2c_rst", 24'({so_i, ri_i, fa_i}), 24'({2'b11, 4'b0000}));
    nr_i = 1'b1;
    for (int k = 0; k < 4; k++) step_i(2'b00, 2'b11, 2'b00, 2'b00, "i2c_rel_quiet");
    step_i(2'b00, 2'b00, 2'b00, 2'b11, "i2c_rel_fall");
    step_i(2'b00, 2'b00, 2'b00, 2'b00, "i2c_rel_after");

    // Directed table on the default instance
    add(2'b00, 2'b00, 2'b00, 2'b00); add(2'b00, 2'b00, 2'b00, 2'b00);
    for (int k = 0; k < 4; k++) add(2'b01, 2'b00, 2'b00, 2'b00);
    add(2'b01, 2'b01, 2'b01, 2'b00); add(2'b01, 2'b01, 2'b00, 2'b00);
    for (int k = 0; k < 4; k++) add(2'b00, 2'b01, 2'b00, 2'b00);
    add(2'b00, 2'b00, 2'b00, 2'b01); add(2'b00, 2'b00, 2'b00, 2'b00);
    // 2-cycle glitch is rejected
    add(2'b01, 2'b00, 2'b00, 2'b00); add(2'b01, 2'b00, 2'b00, 2'b00);
    for (int k = 0; k < 6; k++) add(2'b00, 2'b00, 2'b00, 2'b00);
    // 3-cycle pulse passes; rise and fall 3 cycles apart
    for (int k = 0; k < 3; k++) add(2'b01, 2'b00, 2'b00, 2'b00);
    add(2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b00, 2'b01, 2'b01, 2'b00); add(2'b00, 2'b01, 2'b00, 2'b00);
    add(2'b00, 2'b01, 2'b00, 2'b00); add(2'b00, 2'b00, 2'b00, 2'b01);
    add(2'b00, 2'b00, 2'b00, 2'b00);
    // 2 high, 1 low, 3 high: count restarts after the interruption
    add(2'b01, 2'b00, 2'b00, 2'b00); add(2'b01, 2'b00, 2'b00, 2'b00);
    add(2'b00, 2'b00, 2'b00, 2'b00);
    for (int k = 0; k < 3; k++) add(2'b01, 2'b00, 2'b00, 2'b00);
    add(2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b00, 2'b01, 2'b01, 2'b00); add(2'b00, 2'b01, 2'b00, 2'b00);
    add(2'b00, 2'b01, 2'b00, 2'b00); add(2'b00, 2'b00, 2'b00, 2'b01);
    add(2'b00, 2'b00, 2'b00, 2'b00);
    // Channels move independently and simultaneously
    for (int k = 0; k < 4; k++) add(2'b10, 2'b00, 2'b00, 2'b00);
    add(2'b10, 2'b10, 2'b10, 2'b00);
    for (int k = 0; k < 4; k++) add(2'b01, 2'b10, 2'b00, 2'b00);
    add(2'b01, 2'b01, 2'b01, 2'b10);
    for (int k = 0; k < 4; k++) add(2'b00, 2'b01, 2'b00, 2'b00);
    add(2'b00, 2'b00, 2'b00, 2'b01);

    for (int i = 0; i < tbl.size(); i++) begin
      step_d(tbl[i].v, tbl[i].so, tbl[i].ri, tbl[i].fa, $sformatf("tbl%0d", i));
    end

    // Reset while the counter holds 2 discards the count
    for (int k = 0; k < 4; k++) step_d(2'b01, 2'b00, 2'b00, 2'b00, "midcnt_run");
    nr_d = 1'b0;
    #1 chk("midcnt_rst", 24'({so_d, ri_d, fa_d}), 24'h0);
    @(negedge clk);
    nr_d = 1'b1;
    for (int k = 0; k < 4; k++) step_d(2'b01, 2'b00, 2'b00, 2'b00, "midcnt_restart");
    step_d(2'b01, 2'b01, 2'b01, 2'b00, "midcnt_rise");
    // Reset during the rise pulse drops it without a clock edge
    #1 nr_d = 1'b0;
    #1 chk("midpulse_rst", 24'({so_d, ri_d, fa_d}), 24'h0);
    @(negedge clk);
    nr_d = 1'b1;
    for (int k = 0; k < 4; k++) step_d(2'b01, 2'b00, 2'b00, 2'b00, "postrst_wait");
    step_d(2'b01, 2'b01, 2'b01, 2'b00, "postrst_rise");
    for (int k = 0; k < 3; k++) step_d(2'b01, 2'b01, 2'b00, 2'b00, "postrst_once");

    // Randomized traffic on the default instance
    for (int n = 0; n < 400; n++) begin
      for (int b = 0; b < 2; b++) begin
        if ($urandom_range(0, 3) == 0) in_d[b] = ~in_d[b];
      end
      @(negedge clk);
      chk("rand_def", 24'({so_d, ri_d, fa_d}), 24'({mf_d, mr_d, mfl_d}));
    end

    // Wide instance: every channel random every cycle
    for (int n = 0; n < 300; n++) begin
      in_w = 8'($urandom);
      @(negedge clk);
      chk("wide_out",   24'({so_w, ri_w, fa_w}), 24'({mf_w, mr_w, mfl_w}));
      chk("wide_delay", 24'(so_w), 24'(wq[wq.size() - 4]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
